// File: rtl/mdio_responder.sv
// MDIO (clause-22 style) management responder: decodes ST/OP/PHYAD/REGAD frames
// sampled on MDC edges in the clk domain and bridges them to a simple register-file port.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_DRV,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  input  logic [15:0] RD_DATA,
  output logic        RD_STB,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_HDR, ST_TA, ST_WDATA, ST_RDATA, ST_SKIP
  } state_t;

  state_t      state, state_n;
  logic        mdc_q, rise, fall;
  logic        is_read, is_read_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [10:0] hdr_sr, hdr_sr_n;
  logic [11:0] hdr_full;
  logic [15:0] rd_sr, rd_sr_n;
  logic [4:0]  addr_n;
  logic [15:0] wr_data_n;
  logic        wr_stb_n, rd_stb_n, mdio_in_n, mdio_drv_n;

  assign rise = MDC & ~mdc_q;
  assign fall = ~MDC & mdc_q;
  assign BUSY = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    is_read_n  = is_read;
    bit_cnt_n  = bit_cnt;
    hdr_sr_n   = hdr_sr;
    rd_sr_n    = rd_sr;
    addr_n     = ADDR;
    wr_data_n  = WR_DATA;
    wr_stb_n   = 1'b0;
    rd_stb_n   = 1'b0;
    mdio_in_n  = MDIO_IN;
    mdio_drv_n = MDIO_DRV;
    hdr_full   = {hdr_sr, MDIO_OUT};

    unique case (state)
      ST_IDLE: begin
        bit_cnt_n = '0;
        if (rise && MDIO_OE && !MDIO_OUT) state_n = ST_START;
      end
      ST_START: begin
        if (rise) begin
          if (!MDIO_OE)     state_n = ST_IDLE;
          else if (MDIO_OUT) begin
            state_n   = ST_HDR;
            bit_cnt_n = '0;
          end
        end
      end
      ST_HDR: begin
        if (rise) begin
          if (!MDIO_OE) begin
            state_n = ST_IDLE;
          end else if (bit_cnt == 5'd11) begin
            // hdr_full = {OP[1:0], PHYAD[4:0], REGAD[4:0]}
            if (hdr_full[9:5] == PHY_ADDR &&
                (hdr_full[11:10] == 2'b01 || hdr_full[11:10] == 2'b10)) begin
              state_n   = ST_TA;
              bit_cnt_n = '0;
              is_read_n = (hdr_full[11:10] == 2'b10);
              addr_n    = hdr_full[4:0];
              if (hdr_full[11:10] == 2'b10) begin
                rd_sr_n  = RD_DATA;
                rd_stb_n = 1'b1;
              end
            end else begin
              // Skip counter continues from the 14 frame bits already seen.
              state_n   = ST_SKIP;
              bit_cnt_n = 5'd14;
            end
          end else begin
            hdr_sr_n  = hdr_full[10:0];
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      ST_TA: begin
        if (is_read) begin
          // Read turnaround: release on the first fall, drive 0 on the second.
          if (fall) begin
            if (bit_cnt == 5'd0) begin
              bit_cnt_n = 5'd1;
            end else begin
              mdio_drv_n = 1'b1;
              mdio_in_n  = 1'b0;
              bit_cnt_n  = '0;
              state_n    = ST_RDATA;
            end
          end
        end else if (rise) begin
          if (!MDIO_OE) begin
            state_n = ST_IDLE;
          end else if (bit_cnt == 5'd1) begin
            bit_cnt_n = '0;
            state_n   = ST_WDATA;
          end else begin
            bit_cnt_n = 5'd1;
          end
        end
      end
      ST_WDATA: begin
        if (rise) begin
          if (!MDIO_OE) begin
            state_n = ST_IDLE;
          end else begin
            wr_data_n = {WR_DATA[14:0], MDIO_OUT};
            if (bit_cnt == 5'd15) begin
              wr_stb_n = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              bit_cnt_n = bit_cnt + 5'd1;
            end
          end
        end
      end
      ST_RDATA: begin
        if (fall) begin
          if (bit_cnt == 5'd16) begin
            mdio_drv_n = 1'b0;
            mdio_in_n  = 1'b0;
            state_n    = ST_IDLE;
          end else begin
            mdio_in_n = rd_sr[15];
            rd_sr_n   = {rd_sr[14:0], 1'b0};
            bit_cnt_n = bit_cnt + 5'd1;
          end
        end
      end
      ST_SKIP: begin
        if (rise) begin
          if (bit_cnt == 5'd31) state_n = ST_IDLE;
          else                  bit_cnt_n = bit_cnt + 5'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      mdc_q    <= 1'b0;
      is_read  <= 1'b0;
      bit_cnt  <= '0;
      hdr_sr   <= '0;
      rd_sr    <= '0;
      ADDR     <= '0;
      WR_DATA  <= '0;
      WR_STB   <= 1'b0;
      RD_STB   <= 1'b0;
      MDIO_IN  <= 1'b0;
      MDIO_DRV <= 1'b0;
    end else begin
      state    <= state_n;
      mdc_q    <= MDC;
      is_read  <= is_read_n;
      bit_cnt  <= bit_cnt_n;
      hdr_sr   <= hdr_sr_n;
      rd_sr    <= rd_sr_n;
      ADDR     <= addr_n;
      WR_DATA  <= wr_data_n;
      WR_STB   <= wr_stb_n;
      RD_STB   <= rd_stb_n;
      MDIO_IN  <= mdio_in_n;
      MDIO_DRV <= mdio_drv_n;
    end
  end

endmodule
